// File: rtl/usb_cmd_decoder.sv
// usb_cmd_decoder: parses PC packets popped from the USB in-FIFO, performs
// register writes, register reads or echo, and pushes replies to the out-FIFO.
// Everything runs on iCLK; the FIFOs handle the USB clock crossing.

module usb_cmd_decoder #(
    parameter int          D_BIT  = 32,
    parameter logic [15:0] TO_CYC = 16'd50000
) (
    input  logic             iCLK,
    input  logic             reset,
    input  logic [D_BIT-1:0] iRX_DATA,
    input  logic             iRX_EMPTY,
    output logic             oRX_RD,
    output logic [D_BIT-1:0] oTX_DATA,
    output logic             oTX_WR,
    input  logic             iTX_FULL,
    output logic [7:0]       oREG_ADDR,
    output logic [D_BIT-1:0] oREG_WDATA,
    output logic             oREG_WR,
    output logic             oREG_RD,
    input  logic [D_BIT-1:0] iREG_RDATA,
    output logic             oBUSY,
    output logic [7:0]       oERR_CNT
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WR, S_RD_REQ, S_RD_DATA, S_ECHO, S_REPLY, S_ERR
    } state_t;

    state_t           r_state, w_next;
    logic             r_rdPend;
    logic             r_txValid;
    logic [D_BIT-1:0] r_txData;
    logic [7:0]       r_op, r_addr, r_n, r_idx, r_errCode, r_errCnt;
    logic [15:0]      r_toCnt;

    logic             w_stall, w_lastIdx, w_timeout;
    logic             w_rxRd, w_regWr, w_regRd, w_txLoad, w_hdrLatch, w_idxInc, w_errInc;
    logic [D_BIT-1:0] w_txWord;
    logic [7:0]       w_errCode;

    // A held reply word that cannot be written blocks every new read or push.
    assign w_stall   = r_txValid & iTX_FULL;
    assign w_lastIdx = (r_idx == r_n - 8'd1);
    assign w_timeout = iRX_EMPTY && (r_toCnt >= TO_CYC - 16'd1);

    // Next-state and strobe decode; every read is issued only when the output
    // slot is guaranteed free on the cycle its data arrives.
    always_comb begin
        w_next     = r_state;
        w_rxRd     = 1'b0;
        w_regWr    = 1'b0;
        w_regRd    = 1'b0;
        w_txLoad   = 1'b0;
        w_txWord   = '0;
        w_hdrLatch = 1'b0;
        w_idxInc   = 1'b0;
        w_errInc   = 1'b0;
        w_errCode  = r_errCode;
        case (r_state)
            S_IDLE: begin
                if (!iRX_EMPTY && !w_stall) begin
                    w_rxRd = 1'b1;
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                w_hdrLatch = 1'b1;
                if (iRX_DATA[31:24] != 8'hA5) begin
                    w_errCode = 8'h01;
                    w_next    = S_ERR;
                end else begin
                    case (iRX_DATA[23:16])
                        8'h01: w_next = (iRX_DATA[7:0] == 8'd0) ? S_REPLY : S_WR;
                        8'h02, 8'h03: begin
                            w_txLoad = 1'b1;
                            w_txWord = {8'h5A, iRX_DATA[23:0]};
                            if (iRX_DATA[7:0] == 8'd0)
                                w_next = S_IDLE;
                            else if (iRX_DATA[23:16] == 8'h02)
                                w_next = S_RD_REQ;
                            else
                                w_next = S_ECHO;
                        end
                        default: begin
                            w_errCode = 8'h02;
                            w_next    = S_ERR;
                        end
                    endcase
                end
            end
            S_WR: begin
                if (r_rdPend) begin
                    w_regWr  = 1'b1;
                    w_idxInc = 1'b1;
                    if (w_lastIdx) w_next = S_REPLY;
                end else if (!iRX_EMPTY && !w_stall) begin
                    w_rxRd = 1'b1;
                end else if (w_timeout) begin
                    w_errCode = 8'h03;
                    w_next    = S_ERR;
                end
            end
            S_RD_REQ: begin
                if (!w_stall) begin
                    w_regRd = 1'b1;
                    w_next  = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                w_txLoad = 1'b1;
                w_txWord = iREG_RDATA;
                w_idxInc = 1'b1;
                w_next   = w_lastIdx ? S_IDLE : S_RD_REQ;
            end
            S_ECHO: begin
                if (r_rdPend) begin
                    w_txLoad = 1'b1;
                    w_txWord = iRX_DATA;
                    w_idxInc = 1'b1;
                    if (w_lastIdx) w_next = S_IDLE;
                end else if (!iRX_EMPTY && !w_stall && !iTX_FULL) begin
                    w_rxRd = 1'b1;
                end else if (w_timeout) begin
                    w_errCode = 8'h03;
                    w_next    = S_ERR;
                end
            end
            S_REPLY: begin
                if (!w_stall) begin
                    w_txLoad = 1'b1;
                    w_txWord = {8'h5A, r_op, r_addr, r_n};
                    w_next   = S_IDLE;
                end
            end
            S_ERR: begin
                if (!w_stall) begin
                    w_txLoad = 1'b1;
                    w_txWord = {24'hEE0000, r_errCode};
                    w_errInc = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, header fields, payload index, read-pending flag and error tracking.
    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rdPend  <= 1'b0;
            r_op      <= '0;
            r_addr    <= '0;
            r_n       <= '0;
            r_idx     <= '0;
            r_errCode <= '0;
            r_errCnt  <= '0;
        end else begin
            r_state   <= w_next;
            r_rdPend  <= w_rxRd;
            r_errCode <= w_errCode;
            if (w_hdrLatch) begin
                r_op   <= iRX_DATA[23:16];
                r_addr <= iRX_DATA[15:8];
                r_n    <= iRX_DATA[7:0];
                r_idx  <= '0;
            end else if (w_idxInc) begin
                r_idx <= r_idx + 8'd1;
            end
            if (w_errInc && r_errCnt != 8'hFF) r_errCnt <= r_errCnt + 8'd1;
        end
    end

    // Consecutive RX-empty cycles while waiting for payload words.
    always_ff @(posedge iCLK or posedge reset) begin
        if (reset)
            r_toCnt <= '0;
        else if ((r_state == S_WR || r_state == S_ECHO) && iRX_EMPTY)
            r_toCnt <= r_toCnt + 16'd1;
        else
            r_toCnt <= '0;
    end

    // One-entry output register holding a reply word until the out-FIFO takes it.
    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            r_txValid <= 1'b0;
            r_txData  <= '0;
        end else if (w_txLoad) begin
            r_txValid <= 1'b1;
            r_txData  <= w_txWord;
        end else if (oTX_WR) begin
            r_txValid <= 1'b0;
        end
    end

    assign oRX_RD     = w_rxRd;
    assign oREG_WR    = w_regWr;
    assign oREG_RD    = w_regRd;
    assign oREG_ADDR  = r_addr + r_idx;
    assign oREG_WDATA = w_regWr ? iRX_DATA : '0;
    assign oTX_WR     = r_txValid & ~iTX_FULL;
    assign oTX_DATA   = r_txData;
    assign oBUSY      = (r_state != S_IDLE);
    assign oERR_CNT   = r_errCnt;

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Testbench for usb_cmd_decoder: table-driven packets plus hand-written
// backpressure, timeout and mid-packet reset sequences.

module tb_usb_cmd_decoder;

    logic        iCLK;
    logic        reset;
    logic [31:0] iRX_DATA;
    logic        iRX_EMPTY;
    logic        oRX_RD;
    logic [31:0] oTX_DATA;
    logic        oTX_WR;
    logic        iTX_FULL;
    logic [7:0]  oREG_ADDR;
    logic [31:0] oREG_WDATA;
    logic        oREG_WR;
    logic        oREG_RD;
    logic [31:0] iREG_RDATA;
    logic        oBUSY;
    logic [7:0]  oERR_CNT;

    int testCnt  = 0;
    int failCnt  = 0;
    int violCnt  = 0;
    int cycleCnt = 0;

    logic [31:0] rxMem [0:511];
    int          rxWrPtr = 0;
    int          rxRdPtr = 0;

    logic [31:0] txLog [0:511];
    int          txCyc [0:511];
    int          txCnt = 0;
    logic [7:0]  wrALog [0:511];
    logic [31:0] wrDLog [0:511];
    int          wrCyc [0:511];
    int          wrCnt = 0;

    typedef struct {
        string             name;
        int                nWords;
        logic [0:5][31:0]  words;
        int                nTx;
        logic [0:4][31:0]  tx;
        int                nWr;
        logic [0:3][7:0]   wrA;
        logic [0:3][31:0]  wrD;
    } vec_t;

    vec_t vecs [8];

    usb_cmd_decoder #(.D_BIT(32), .TO_CYC(16'd100)) dut (
        .iCLK(iCLK), .reset(reset),
        .iRX_DATA(iRX_DATA), .iRX_EMPTY(iRX_EMPTY), .oRX_RD(oRX_RD),
        .oTX_DATA(oTX_DATA), .oTX_WR(oTX_WR), .iTX_FULL(iTX_FULL),
        .oREG_ADDR(oREG_ADDR), .oREG_WDATA(oREG_WDATA), .oREG_WR(oREG_WR),
        .oREG_RD(oREG_RD), .iREG_RDATA(iREG_RDATA),
        .oBUSY(oBUSY), .oERR_CNT(oERR_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    assign iRX_EMPTY = (rxRdPtr == rxWrPtr);

    // Non-show-ahead in-FIFO and register file returning addr ^ C0DE0000.
    always @(posedge iCLK) begin
        cycleCnt <= cycleCnt + 1;
        if (oRX_RD) begin
            iRX_DATA <= rxMem[rxRdPtr];
            rxRdPtr  <= rxRdPtr + 1;
        end
        if (oREG_RD) iREG_RDATA <= 32'hC0DE0000 ^ {24'h0, oREG_ADDR};
    end

    // Log TX words and register writes, and count protocol violations.
    always @(negedge iCLK) begin
        if (!reset) begin
            if (oTX_WR && txCnt < 512) begin
                txLog[txCnt] = oTX_DATA;
                txCyc[txCnt] = cycleCnt;
                txCnt = txCnt + 1;
            end
            if (oREG_WR && wrCnt < 512) begin
                wrALog[wrCnt] = oREG_ADDR;
                wrDLog[wrCnt] = oREG_WDATA;
                wrCyc[wrCnt]  = cycleCnt;
                wrCnt = wrCnt + 1;
            end
            if (oREG_WR && oREG_RD) violCnt = violCnt + 1;
            if (oTX_WR && iTX_FULL) violCnt = violCnt + 1;
            if (oRX_RD && iRX_EMPTY) violCnt = violCnt + 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(string n, int nw, logic [0:5][31:0] w, int nt,
                                   logic [0:4][31:0] t, int nr, logic [0:3][7:0] a,
                                   logic [0:3][31:0] d);
        vec_t v;
        v.name = n; v.nWords = nw; v.words = w; v.nTx = nt; v.tx = t;
        v.nWr = nr; v.wrA = a; v.wrD = d;
        return v;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCnt = testCnt + 1;
        if (act !== exp) begin
            failCnt = failCnt + 1;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic pushRx(input logic [31:0] w);
        rxMem[rxWrPtr] = w;
        rxWrPtr = rxWrPtr + 1;
    endtask

    task automatic applyStimulus(input vec_t v);
        int txBase = txCnt;
        int wrBase = wrCnt;
        int guard  = 0;
        for (int k = 0; k < v.nWords; k++) pushRx(v.words[k]);
        while (!(txCnt >= txBase + v.nTx && rxRdPtr == rxWrPtr && !oBUSY) && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) checkOutput({v.name, "_complete"}, 32'd0, 32'd1);
        repeat (4) tick();
        checkOutput({v.name, "_txcount"}, txCnt - txBase, v.nTx);
        for (int k = 0; k < v.nTx; k++)
            if (k < txCnt - txBase)
                checkOutput($sformatf("%s_tx%0d", v.name, k), txLog[txBase + k], v.tx[k]);
        checkOutput({v.name, "_wrcount"}, wrCnt - wrBase, v.nWr);
        for (int k = 0; k < v.nWr; k++)
            if (k < wrCnt - wrBase) begin
                checkOutput($sformatf("%s_wraddr%0d", v.name, k), {24'h0, wrALog[wrBase + k]}, {24'h0, v.wrA[k]});
                checkOutput($sformatf("%s_wrdata%0d", v.name, k), wrDLog[wrBase + k], v.wrD[k]);
            end
    endtask

    initial begin
        int base, wrBase, guard, rdStall, txAtStall;

        vecs[0] = mkVec("write", 4, {32'hA5011003, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0},
                        1, {32'h5A011003, 32'h0, 32'h0, 32'h0, 32'h0},
                        3, {8'h10, 8'h11, 8'h12, 8'h00}, {32'h11, 32'h22, 32'h33, 32'h0});
        vecs[1] = mkVec("read", 1, {32'hA502FE03, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                        4, {32'h5A02FE03, 32'hC0DE00FE, 32'hC0DE00FF, 32'hC0DE0000, 32'h0},
                        0, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[2] = mkVec("badsync", 1, {32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                        1, {32'hEE000001, 32'h0, 32'h0, 32'h0, 32'h0},
                        0, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[3] = mkVec("badop", 1, {32'hA5070000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                        1, {32'hEE000002, 32'h0, 32'h0, 32'h0, 32'h0},
                        0, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[4] = mkVec("echo", 5, {32'hA5030204, 32'hCAFEF00D, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h0},
                        5, {32'h5A030204, 32'hCAFEF00D, 32'h12345678, 32'h0, 32'hFFFFFFFF},
                        0, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[5] = mkVec("wr_n0", 1, {32'hA5014200, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                        1, {32'h5A014200, 32'h0, 32'h0, 32'h0, 32'h0},
                        0, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[6] = mkVec("rd_n0", 1, {32'hA5027700, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                        1, {32'h5A027700, 32'h0, 32'h0, 32'h0, 32'h0},
                        0, {8'h0, 8'h0, 8'h0, 8'h0}, {32'h0, 32'h0, 32'h0, 32'h0});
        vecs[7] = mkVec("wr_wrap", 3, {32'hA501FF02, 32'hAA, 32'hBB, 32'h0, 32'h0, 32'h0},
                        1, {32'h5A01FF02, 32'h0, 32'h0, 32'h0, 32'h0},
                        2, {8'hFF, 8'h00, 8'h00, 8'h00}, {32'hAA, 32'hBB, 32'h0, 32'h0});

        reset    = 1'b1;
        iTX_FULL = 1'b0;
        repeat (3) tick();
        checkOutput("reset_busy", {31'h0, oBUSY}, 32'd0);
        checkOutput("reset_strobes", {28'h0, oRX_RD, oTX_WR, oREG_WR, oREG_RD}, 32'd0);
        checkOutput("reset_errcnt", {24'h0, oERR_CNT}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
        checkOutput("errcnt_after_table", {24'h0, oERR_CNT}, 32'd2);

        // Echo with 20 cycles of out-FIFO backpressure mid-packet.
        base = txCnt;
        pushRx(32'hA5030004);
        pushRx(32'hDEADBEEF); pushRx(32'h01234567); pushRx(32'h89ABCDEF); pushRx(32'h55AA55AA);
        guard = 0;
        while (txCnt < base + 2 && guard < 200) begin tick(); guard++; end
        checkOutput("bp_reach_stall", {31'h0, guard < 200}, 32'd1);
        iTX_FULL  = 1'b1;
        txAtStall = txCnt;
        rdStall   = 0;
        for (int k = 0; k < 20; k++) begin
            if (oRX_RD) rdStall++;
            tick();
        end
        checkOutput("bp_rd_during_stall", rdStall, 32'd0);
        checkOutput("bp_tx_during_stall", txCnt - txAtStall, 32'd0);
        checkOutput("bp_busy_during_stall", {31'h0, oBUSY}, 32'd1);
        iTX_FULL = 1'b0;
        guard = 0;
        while (!(txCnt >= base + 5 && !oBUSY) && guard < 300) begin tick(); guard++; end
        repeat (4) tick();
        checkOutput("bp_txcount", txCnt - base, 32'd5);
        checkOutput("bp_tx0", txLog[base], 32'h5A030004);
        checkOutput("bp_tx1", txLog[base + 1], 32'hDEADBEEF);
        checkOutput("bp_tx2", txLog[base + 2], 32'h01234567);
        checkOutput("bp_tx3", txLog[base + 3], 32'h89ABCDEF);
        checkOutput("bp_tx4", txLog[base + 4], 32'h55AA55AA);

        // Write packet missing 3 of 5 payload words: timeout after TO_CYC empty cycles.
        base   = txCnt;
        wrBase = wrCnt;
        pushRx(32'hA5010005); pushRx(32'h0000AAAA); pushRx(32'h0000BBBB);
        guard = 0;
        while (txCnt == base && guard < 400) begin tick(); guard++; end
        repeat (4) tick();
        checkOutput("to_wrcount", wrCnt - wrBase, 32'd2);
        checkOutput("to_wraddr0", {24'h0, wrALog[wrBase]}, 32'h00);
        checkOutput("to_wrdata0", wrDLog[wrBase], 32'h0000AAAA);
        checkOutput("to_wraddr1", {24'h0, wrALog[wrBase + 1]}, 32'h01);
        checkOutput("to_wrdata1", wrDLog[wrBase + 1], 32'h0000BBBB);
        checkOutput("to_txcount", txCnt - base, 32'd1);
        checkOutput("to_txword", txLog[base], 32'hEE000003);
        checkOutput("to_delay_min", {31'h0, (txCyc[base] - wrCyc[wrBase + 1]) >= 100}, 32'd1);
        checkOutput("to_delay_max", {31'h0, (txCyc[base] - wrCyc[wrBase + 1]) <= 104}, 32'd1);
        checkOutput("to_busy_after", {31'h0, oBUSY}, 32'd0);
        checkOutput("to_errcnt", {24'h0, oERR_CNT}, 32'd3);

        // Reset in the middle of an echo packet, then a normal packet.
        base = txCnt;
        pushRx(32'hA5030008); pushRx(32'h11111111); pushRx(32'h22222222); pushRx(32'h33333333);
        guard = 0;
        while (txCnt < base + 4 && guard < 200) begin tick(); guard++; end
        repeat (5) tick();
        checkOutput("rst_busy_before", {31'h0, oBUSY}, 32'd1);
        reset = 1'b1;
        #2;
        checkOutput("rst_strobes", {28'h0, oRX_RD, oTX_WR, oREG_WR, oREG_RD}, 32'd0);
        checkOutput("rst_busy", {31'h0, oBUSY}, 32'd0);
        checkOutput("rst_txdata", oTX_DATA, 32'd0);
        checkOutput("rst_regaddr", {24'h0, oREG_ADDR}, 32'd0);
        checkOutput("rst_wdata", oREG_WDATA, 32'd0);
        checkOutput("rst_errcnt", {24'h0, oERR_CNT}, 32'd0);
        rxWrPtr = rxRdPtr;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        checkOutput("rst_no_tx", txCnt - base, 32'd4);
        applyStimulus(vecs[0]);

        checkOutput("protocol_violations", violCnt, 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
